// File: rtl/fetch_unit_if.sv
// Fetch unit bus: next-PC loop, pipeline control, instruction memory
// handshake and the IF/ID register outputs, bundled into one interface.
interface fetch_unit_if;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        redirect;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  // Fetch unit side
  modport master (
    output pc, imem_req, imem_addr, if_id_pc, if_id_inst, if_id_valid,
    input  npc, redirect, stall, flush, imem_rvalid, imem_rdata
  );

  // Environment side: next-PC logic, decode stage and instruction memory
  modport slave (
    input  pc, imem_req, imem_addr, if_id_pc, if_id_inst, if_id_valid,
    output npc, redirect, stall, flush, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding fetch FSM (ISSUE/WAIT/HOLD)
// feeding the IF/ID pipeline register. A redirect while a fetch is in
// flight marks the response for dropping; a response that arrives while
// decode is stalled parks in a one-entry hold buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        drop_q, drop_d;
  ifid_t       ifid_q, ifid_d;

  logic        req;
  logic        load;
  logic [31:0] load_inst;

  // FSM state, PC, drop flag and hold buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: redirect always wins over stall for pc and buffer
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    drop_d    = drop_q;
    req       = 1'b0;
    load      = 1'b0;
    load_inst = hold_q;
    case (state_q)
      ISSUE: begin
        // The request goes out even on redirect; its response is dropped.
        req     = 1'b1;
        state_d = WAIT;
        if (bus.redirect) begin
          pc_d   = bus.npc;
          drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          pc_d = bus.npc;
          if (bus.imem_rvalid) begin
            // Stale response retires now, so nothing is left to drop.
            drop_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            drop_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (drop_q) begin
            // pc already holds the redirect target.
            drop_d  = 1'b0;
            state_d = ISSUE;
          end else if (bus.stall) begin
            hold_d  = bus.imem_rdata;
            state_d = HOLD;
          end else begin
            load      = 1'b1;
            load_inst = bus.imem_rdata;
            pc_d      = bus.npc;
            state_d   = ISSUE;
          end
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          pc_d    = bus.npc;
          hold_d  = '0;
          state_d = ISSUE;
        end else if (!bus.stall) begin
          load      = 1'b1;
          load_inst = hold_q;
          pc_d      = bus.npc;
          state_d   = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  // IF/ID next value: flush beats load and stall; idle without stall is a bubble
  always_comb begin
    ifid_d = ifid_q;
    if (bus.flush) begin
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
    end else if (load) begin
      ifid_d = '{pc: pc_q, inst: load_inst, valid: 1'b1};
    end else if (!bus.stall) begin
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q <= '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};
    end else begin
      ifid_q <= ifid_d;
    end
  end

  // Request is masked during reset since the state already sits in ISSUE.
  assign bus.imem_req    = req & ~rst;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.if_id_pc    = ifid_q.pc;
  assign bus.if_id_inst  = ifid_q.inst;
  assign bus.if_id_valid = ifid_q.valid;

endmodule
